fft_op_unit: RTL and testbench

Pipelined radix-2 decimation-in-time butterfly for the FFT datapath, with a combinational bit-reversal index helper for input/output reordering. Each accepted sample set (a, b, twiddle w) produces c = a + w·b and d = a − w·b on complex signed fixed-point operands. The FFT controller uses it to sequence stages and to generate bit-reversed memory addresses.

---
 rtl/fft_op_unit.sv | 110 +++++++++++
 tb/tb_fft_op_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fft_op_unit.sv
// Radix-2 DIT butterfly (c = a + w*b, d = a - w*b) on complex signed fixed point,
// two-stage pipeline, plus a combinational bit-reversal index helper.
module fft_op_unit #(
  parameter int W    = 64,
  parameter int FRAC = 32,
  parameter int LOGN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    ar,
  input  logic [W-1:0]    ai,
  input  logic [W-1:0]    br,
  input  logic [W-1:0]    bi,
  input  logic [W-1:0]    wr,
  input  logic [W-1:0]    wi,
  output logic            out_valid,
  output logic [W-1:0]    cr,
  output logic [W-1:0]    ci,
  output logic [W-1:0]    dr,
  output logic [W-1:0]    di,
  input  logic [LOGN-1:0] rev_in,
  output logic [LOGN-1:0] rev_out
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam logic [SW-1:0] RND = {{(SW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  logic signed [PW-1:0] wr_x, wi_x, br_x, bi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [SW-1:0]        sum_r, sum_i;
  logic [W-1:0]         pr_d, pi_d;
  logic [W-1:0]         pr_q, pi_q, ar_q, ai_q;
  logic                 v1_q;
  logic [W-1:0]         cr_d, ci_d, dr_d, di_d;
  logic [W-1:0]         cr_q, ci_q, dr_q, di_q;
  logic                 out_valid_q;
  logic                 unused_round_bits;

  assign wr_x = {{W{wr[W-1]}}, wr};
  assign wi_x = {{W{wi[W-1]}}, wi};
  assign br_x = {{W{br[W-1]}}, br};
  assign bi_x = {{W{bi[W-1]}}, bi};

  assign p_rr = wr_x * br_x;
  assign p_ii = wi_x * bi_x;
  assign p_ri = wr_x * bi_x;
  assign p_ir = wi_x * br_x;

  // One extra bit keeps the sum/difference of two full products exact before rounding.
  assign sum_r = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii} + RND;
  assign sum_i = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir} + RND;

  // Selecting bits [FRAC +: W] is the arithmetic shift by FRAC followed by wrap to W.
  assign pr_d = sum_r[FRAC +: W];
  assign pi_d = sum_i[FRAC +: W];

  assign unused_round_bits = ^{sum_r[FRAC-1:0], sum_r[SW-1:FRAC+W],
                               sum_i[FRAC-1:0], sum_i[SW-1:FRAC+W]};

  assign cr_d = ar_q + pr_q;
  assign ci_d = ai_q + pi_q;
  assign dr_d = ar_q - pr_q;
  assign di_d = ai_q - pi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      pr_q        <= '0;
      pi_q        <= '0;
      ar_q        <= '0;
      ai_q        <= '0;
      out_valid_q <= 1'b0;
      cr_q        <= '0;
      ci_q        <= '0;
      dr_q        <= '0;
      di_q        <= '0;
    end else begin
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (in_valid) begin
        pr_q <= pr_d;
        pi_q <= pi_d;
        ar_q <= ar;
        ai_q <= ai;
      end
      if (v1_q) begin
        cr_q <= cr_d;
        ci_q <= ci_d;
        dr_q <= dr_d;
        di_q <= di_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign cr        = cr_q;
  assign ci        = ci_q;
  assign dr        = dr_q;
  assign di        = di_q;

  always_comb begin
    rev_out = '0;
    for (int k = 0; k < LOGN; k++) begin
      rev_out[k] = rev_in[LOGN-1-k];
    end
  end

endmodule

// File: tb/tb_fft_op_unit.sv
// Directed bench for fft_op_unit: fixed-point butterfly cases, reset flush,
// streaming with a gap, and bit reversal.
module tb_fft_op_unit;

  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] MONE = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] ar, ai, br, bi, wr, wi;
  logic        out_valid;
  logic [63:0] cr, ci, dr, di;
  logic [3:0]  rev_in, rev_out;

  int n_checks = 0;
  int n_fail   = 0;

  fft_op_unit #(.W(64), .FRAC(32), .LOGN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .wr        (wr),
    .wi        (wi),
    .out_valid (out_valid),
    .cr        (cr),
    .ci        (ci),
    .dr        (dr),
    .di        (di),
    .rev_in    (rev_in),
    .rev_out   (rev_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [63:0] ecr, input logic [63:0] eci,
                      input logic [63:0] edr, input logic [63:0] edi);
    chk({tag, ".cr"}, cr, ecr);
    chk({tag, ".ci"}, ci, eci);
    chk({tag, ".dr"}, dr, edr);
    chk({tag, ".di"}, di, edi);
  endtask

  // Present one beat, confirm nothing emerges after one edge, and that it is valid after two.
  task automatic beat(input string tag, input logic [63:0] a_r, input logic [63:0] a_i,
                      input logic [63:0] b_r, input logic [63:0] b_i,
                      input logic [63:0] w_r, input logic [63:0] w_i);
    @(negedge clk);
    ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  logic [63:0] s_ar[20], s_ai[20], s_br[20], s_bi[20], s_wr[20], s_wi[20];
  logic [63:0] e_cr[20], e_ci[20], e_dr[20], e_di[20];
  logic        vld[25];
  int          idx[25];

  initial begin
    logic [63:0] last_cr;
    logic [3:0]  r, e;
    int          b;

    rst = 1'b1; in_valid = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0; wr = '0; wi = '0; rev_in = '0;
    #1;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk4("rst", 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    beat("ident", 64'h0000_0003_0000_0000, 64'd0, 64'h0000_0002_0000_0000, 64'd0, ONE, 64'd0);
    chk4("ident", 64'h0000_0005_0000_0000, 64'd0, 64'h0000_0001_0000_0000, 64'd0);

    beat("mj", 64'd0, 64'd0, ONE, 64'd0, 64'd0, MONE);
    chk4("mj", 64'd0, MONE, 64'd0, ONE);

    beat("rnd_pos", 64'd0, 64'd0, 64'd1, 64'd0, 64'h0000_0000_8000_0000, 64'd0);
    chk4("rnd_pos", 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

    beat("rnd_neg", 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 64'd0);
    chk4("rnd_neg", 64'd0, 64'd0, 64'd0, 64'd0);

    // a = 1+2j, b = 3+4j, w = 0.5-0.5j -> w*b = 3.5+0.5j
    beat("cross", ONE, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 64'h0000_0004_0000_0000,
         64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000);
    chk4("cross", 64'h0000_0004_8000_0000, 64'h0000_0002_8000_0000,
         64'hFFFF_FFFD_8000_0000, 64'h0000_0001_8000_0000);

    beat("wrap", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, ONE, 64'd0, 64'd1, 64'd0);
    chk4("wrap", 64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFE, 64'd0);

    rev_in = 4'b0001; #1 chk("rev.0001", {60'd0, rev_out}, 64'b1000);
    rev_in = 4'b0110; #1 chk("rev.0110", {60'd0, rev_out}, 64'b0110);
    rev_in = 4'b1011; #1 chk("rev.1011", {60'd0, rev_out}, 64'b1101);
    rev_in = 4'b0000; #1 chk("rev.0000", {60'd0, rev_out}, 64'b0000);
    rev_in = 4'b1111; #1 chk("rev.1111", {60'd0, rev_out}, 64'b1111);
    for (int x = 0; x < 16; x++) begin
      e = 4'(x);
      e = {e[0], e[1], e[2], e[3]};
      rev_in = 4'(x);
      #1;
      r = rev_out;
      chk($sformatf("rev.sweep%0d", x), {60'd0, r}, {60'd0, e});
      rev_in = r;
      #1;
      chk($sformatf("rev.twice%0d", x), {60'd0, rev_out}, 64'(x));
    end

    // Reset with two beats in flight: outputs clear at once and nothing surfaces afterwards.
    @(negedge clk);
    ar = ONE; ai = ONE; br = ONE; bi = ONE; wr = ONE; wi = 64'd0; in_valid = 1'b1;
    @(negedge clk);
    ar = 64'h0000_0009_0000_0000;
    @(posedge clk);
    #1 chk("rstmid.pre_valid", {63'd0, out_valid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid.out_valid", {63'd0, out_valid}, 64'd0);
    chk4("rstmid", 64'd0, 64'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk($sformatf("rstmid.stale%0d", t), {63'd0, out_valid}, 64'd0);
    end

    // Streaming: twiddle alternates between 1 and j so w*b is exact and easy to predict.
    for (int i = 0; i < 20; i++) begin
      s_br[i] = 64'(i + 1) * 64'h0F1E_2D3C_4B5A_6978;
      s_bi[i] = ~s_br[i];
      s_ar[i] = 64'h7FFF_FFFF_FFFF_FFF0 + 64'(i);
      s_ai[i] = 64'(i) << 40;
      if (i % 2 == 0) begin
        s_wr[i] = ONE; s_wi[i] = 64'd0;
        e_cr[i] = s_ar[i] + s_br[i]; e_ci[i] = s_ai[i] + s_bi[i];
        e_dr[i] = s_ar[i] - s_br[i]; e_di[i] = s_ai[i] - s_bi[i];
      end else begin
        s_wr[i] = 64'd0; s_wi[i] = ONE;
        e_cr[i] = s_ar[i] - s_bi[i]; e_ci[i] = s_ai[i] + s_br[i];
        e_dr[i] = s_ar[i] + s_bi[i]; e_di[i] = s_ai[i] - s_br[i];
      end
    end
    b = 0;
    for (int t = 0; t < 25; t++) begin
      vld[t] = (t < 16) || (t >= 19 && t < 23);
      idx[t] = vld[t] ? b : 0;
      if (vld[t]) b++;
    end

    last_cr = cr;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        chk($sformatf("stream.valid%0d", t), {63'd0, out_valid}, {63'd0, vld[t-2]});
        if (vld[t-2]) begin
          chk4($sformatf("stream.b%0d", idx[t-2]), e_cr[idx[t-2]], e_ci[idx[t-2]],
               e_dr[idx[t-2]], e_di[idx[t-2]]);
          last_cr = e_cr[idx[t-2]];
        end else begin
          chk($sformatf("stream.hold%0d", t), cr, last_cr);
        end
      end
      in_valid = vld[t];
      if (vld[t]) begin
        ar = s_ar[idx[t]]; ai = s_ai[idx[t]]; br = s_br[idx[t]];
        bi = s_bi[idx[t]]; wr = s_wr[idx[t]]; wi = s_wi[idx[t]];
      end
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
